gen_user_cmd_pulse: RTL
=======================

// Module: gen_user_cmd_pulse
// PURPOSE
//  Multi-channel successor of the single-register user reset generator. Polls N_CH
//  command bytes in the 8-bit register memory over port B, round-robin. A byte equal
//  to ARM_CODE fires a registered pulse of PULSE_LEN cycles on that channel.
//  The block then writes 8'h00 back to the register to disarm it.
//  Sits between the register memory port B and user logic: resets, counter clears, run strobes.
// PARAMETERS
//  N_CH      4      number of command channels (1..16)
//  BASE_ADDR 5'd1   port-B address of channel 0; channel i at BASE_ADDR+i (5-bit, wraps mod 32)
//  ARM_CODE  8'h0F  byte value that fires a channel
//  POLL_DIV  100    cycles between poll slots (>= RD_LAT+5)
//  RD_LAT    2      port-B read latency in cycles (0..7)
//  PULSE_LEN 5      pulse width in cycles (1..255)
// PORTS
//  CLK                   in   1     system clock
//  RST_N                 in   1     synchronous active-low reset
//  mem8_in_port_b        in   8     read data from register memory
//  mem8_out_port_b       out  8     write data (always 8'h00 during write-back)
//  mem8_addr_port_b      out  5     register address
//  mem8_access_en_port_b out  1     port access enable
//  mem8_w_enable_port_b  out  1     write enable
//  PULSE                 out  N_CH  per-channel pulse, PULSE_LEN cycles wide
//  PULSE_STB             out  N_CH  one-cycle strobe on the first cycle of each pulse
//  RST                   out  1     OR-reduction of PULSE
//  BUSY                  out  1     high whenever FSM is not IDLE
// BEHAVIOUR
//  Reset (RST_N=0 at posedge):
//   - All outputs go to 0; mem8_out_port_b=8'h00.
//   - Divider=0, channel index ch=0, FSM=IDLE, pulse counters cleared.
//   - Reset overrides everything, including an in-flight write (we drops at that edge).
//  Divider: counts 0..POLL_DIV-1 and wraps; tick asserts when count==POLL_DIV-1.
//  FSM states IDLE, RD, CHK, WR:
//   - IDLE: on tick go to RD. A tick while not IDLE is dropped, not queued.
//   - RD: access_en=1, we=0, addr=BASE_ADDR+ch, held for RD_LAT+1 cycles.
//     mem8_in_port_b is captured on the last RD cycle.
//   - CHK: 1 cycle, access_en=0.
//     If captured==ARM_CODE: fire channel ch, go to WR.
//     Else: ch advances, go to IDLE.
//   - WR: access_en=1, we=1, addr=BASE_ADDR+ch, out=8'h00, for exactly 2 cycles.
//     Then ch advances, go to IDLE.
//   - ch advance: ch==N_CH-1 wraps to 0.
//  Addressing: addr and access_en are 0 whenever the FSM is in IDLE or CHK.
//  Pulse timing: firing in CHK sets PULSE[ch] and PULSE_STB[ch] on the next edge.
//   - PULSE stays high exactly PULSE_LEN cycles; PULSE_STB is high 1 cycle.
//   - Latency, tick to PULSE rising: RD_LAT+3 cycles.
//  Retrigger while a channel's pulse is active: the counter restarts, pulse extends to
//   PULSE_LEN from the new strobe, and PULSE_STB fires again.
//  Channels are independent. Several may be high simultaneously from successive polls.
//  Values other than ARM_CODE are ignored and never written.
//  Full sweep period is N_CH*POLL_DIV cycles.
//  All outputs registered; no combinational path from mem8_in_port_b to any output.
// TESTING (N_CH=4, BASE_ADDR=1, ARM_CODE=0x0F, POLL_DIV=16, RD_LAT=2, PULSE_LEN=5)
//  1. All regs 0x00, run 200 cycles.
//     -> reads at addr 1,2,3,4,1,... every 16 cycles; we never 1; PULSE=0.
//  2. Reg3=0x0F (ch2).
//     -> PULSE[2] high exactly 5 cycles; PULSE_STB[2] 1 cycle; RST follows PULSE[2].
//     -> 2-cycle write of 0x00 to addr 3; reg3 reads 0x00 on next sweep; no second pulse.
//  3. Reg1=0x0E and reg2=0xFF.
//     -> no pulses, no writes; registers unchanged.
//  4. Rearm reg1=0x0F while PULSE[0] still high (PULSE_LEN=255 build).
//     -> second PULSE_STB[0]; PULSE[0] stays high 255 cycles after the second strobe.
//  5. Assert RST_N=0 during WR cycle 1.
//     -> next edge: we=0, access_en=0, PULSE=0, ch=0.
//     -> after release, first read is at addr 1.
//  6. Reg1..4 all 0x0F.
//     -> pulses on ch0..3 in order, 16 cycles apart; each register written 0x00 once.

Source files
------------

// File: rtl/gen_user_cmd_pulse.sv
// Round-robin poller of N_CH command bytes on register-memory port B. An armed byte
// fires a registered per-channel pulse and is written back to 8'h00 to disarm it.
module gen_user_cmd_pulse #(
  parameter int unsigned N_CH      = 4,
  parameter logic [4:0]  BASE_ADDR = 5'd1,
  parameter logic [7:0]  ARM_CODE  = 8'h0F,
  parameter int unsigned POLL_DIV  = 100,
  parameter int unsigned RD_LAT    = 2,
  parameter int unsigned PULSE_LEN = 5
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [7:0]      mem8_in_port_b,
  output logic [7:0]      mem8_out_port_b,
  output logic [4:0]      mem8_addr_port_b,
  output logic            mem8_access_en_port_b,
  output logic            mem8_w_enable_port_b,
  output logic [N_CH-1:0] PULSE,
  output logic [N_CH-1:0] PULSE_STB,
  output logic            RST,
  output logic            BUSY
);

  localparam int unsigned ChW  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned DivW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;

  typedef enum logic [1:0] {StIdle, StRd, StChk, StWr} state_e;

  state_e            state_q, state_d;
  logic [ChW-1:0]    ch_q, ch_d, ch_nxt;
  logic [DivW-1:0]   div_q, div_d;
  logic [2:0]        phase_q, phase_d;
  logic [7:0]        cap_q, cap_d;
  logic              tick;
  logic [N_CH-1:0]   fire;

  logic [4:0]        addr_q, addr_d;
  logic              en_q, en_d;
  logic              we_q, we_d;
  logic              busy_q, busy_d;
  logic              rst_q, rst_d;
  logic [N_CH-1:0]   pulse_q, pulse_d;
  logic [N_CH-1:0]   stb_q, stb_d;
  logic [7:0]        cnt_q [N_CH];
  logic [7:0]        cnt_d [N_CH];

  // Free-running poll divider; ticks arriving outside IDLE are simply lost.
  assign tick  = (div_q == DivW'(POLL_DIV - 1));
  assign div_d = tick ? '0 : div_q + DivW'(1);

  assign ch_nxt = (ch_q == ChW'(N_CH - 1)) ? '0 : ch_q + ChW'(1);

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    phase_d = phase_q;
    cap_d   = cap_q;
    fire    = '0;
    unique case (state_q)
      StIdle: begin
        if (tick) begin
          state_d = StRd;
          phase_d = '0;
        end
      end
      StRd: begin
        // Data is valid RD_LAT cycles after the address, i.e. on the last RD cycle.
        if (phase_q == 3'(RD_LAT)) begin
          cap_d   = mem8_in_port_b;
          state_d = StChk;
        end else begin
          phase_d = phase_q + 3'd1;
        end
      end
      StChk: begin
        if (cap_q == ARM_CODE) begin
          for (int i = 0; i < int'(N_CH); i++) begin
            if (ch_q == ChW'(i)) fire[i] = 1'b1;
          end
          state_d = StWr;
          phase_d = '0;
        end else begin
          ch_d    = ch_nxt;
          state_d = StIdle;
        end
      end
      StWr: begin
        if (phase_q == 3'd1) begin
          ch_d    = ch_nxt;
          state_d = StIdle;
        end else begin
          phase_d = phase_q + 3'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Port-B controls are registered from the next state so they line up with it.
  always_comb begin
    en_d   = (state_d == StRd) || (state_d == StWr);
    we_d   = (state_d == StWr);
    addr_d = en_d ? BASE_ADDR + 5'(ch_d) : 5'd0;
    busy_d = (state_d != StIdle);
  end

  // A fire reloads the counter, so a retrigger extends the pulse from the new strobe.
  always_comb begin
    pulse_d = '0;
    stb_d   = fire;
    for (int i = 0; i < int'(N_CH); i++) begin
      cnt_d[i] = cnt_q[i];
      if (fire[i]) begin
        cnt_d[i] = 8'(PULSE_LEN);
      end else if (cnt_q[i] != 8'd0) begin
        cnt_d[i] = cnt_q[i] - 8'd1;
      end
      pulse_d[i] = fire[i] || (cnt_q[i] > 8'd1);
    end
    rst_d = |pulse_d;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= StIdle;
      ch_q    <= '0;
      div_q   <= '0;
      phase_q <= '0;
      cap_q   <= '0;
      addr_q  <= '0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      rst_q   <= 1'b0;
      pulse_q <= '0;
      stb_q   <= '0;
      for (int i = 0; i < int'(N_CH); i++) cnt_q[i] <= 8'd0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      div_q   <= div_d;
      phase_q <= phase_d;
      cap_q   <= cap_d;
      addr_q  <= addr_d;
      en_q    <= en_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      rst_q   <= rst_d;
      pulse_q <= pulse_d;
      stb_q   <= stb_d;
      for (int i = 0; i < int'(N_CH); i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Write-back data is always the disarm value.
  assign mem8_out_port_b       = 8'h00;
  assign mem8_addr_port_b      = addr_q;
  assign mem8_access_en_port_b = en_q;
  assign mem8_w_enable_port_b  = we_q;
  assign PULSE                 = pulse_q;
  assign PULSE_STB             = stb_q;
  assign RST                   = rst_q;
  assign BUSY                  = busy_q;

endmodule
